// File: rtl/pixel_fifo.sv
// Pixel FIFO: synchronous single-clock FIFO for packed {r,g,b} pixel words.
// Supports standard registered-read mode and first-word-fall-through mode.
// Status flags are registered and always consistent with the registered count.
module pixel_fifo #(
  parameter int DATA_W   = 24,
  parameter int ADDR_W   = 6,
  parameter int AF_LEVEL = 56,
  parameter int AE_LEVEL = 8,
  parameter int FWFT     = 0
) (
  input  logic              clk_100mhz,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LP_AF    = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] LP_AE    = (ADDR_W + 1)'(AE_LEVEL);
  localparam logic [ADDR_W:0] LP_ONE   = (ADDR_W + 1)'(1);

  // Pixel storage; deliberately not reset, stale words are unreachable
  // because count and the pointers are cleared instead.
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [ADDR_W-1:0] r_wrPtr;
  logic [ADDR_W-1:0] r_rdPtr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_rdData;
  logic              r_rdValid;
  logic              r_full;
  logic              r_empty;
  logic              r_almostFull;
  logic              r_almostEmpty;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_rdAcc;
  logic              w_wrAcc;
  logic              w_memRead;
  logic              w_validNext;
  logic              w_overflowHit;
  logic              w_underflowHit;
  logic [ADDR_W:0]   w_memWords;
  logic [ADDR_W:0]   w_countNext;
  logic              w_fullNext;
  logic              w_emptyNext;
  logic              w_almostFullNext;
  logic              w_almostEmptyNext;

  // Words still sitting in the array; in FWFT mode the presented word lives
  // in the output register but is still part of count.
  assign w_memWords = (FWFT != 0) ? (r_count - {{ADDR_W{1'b0}}, r_rdValid}) : r_count;

  // Acceptance of reads and writes, output-register loading and next count.
  always_comb begin
    w_rdAcc     = 1'b0;
    w_memRead   = 1'b0;
    w_validNext = 1'b0;
    if (FWFT != 0) begin
      w_rdAcc     = rd_en && r_rdValid;
      w_memRead   = (w_memWords != '0) && (!r_rdValid || w_rdAcc);
      w_validNext = w_memRead || (r_rdValid && !w_rdAcc);
    end else begin
      w_rdAcc     = rd_en && !r_empty;
      w_memRead   = w_rdAcc;
      w_validNext = w_rdAcc;
    end

    w_wrAcc        = wr_en && (!r_full || w_rdAcc);
    w_overflowHit  = wr_en && !w_wrAcc;
    w_underflowHit = rd_en && !w_rdAcc;

    w_countNext = r_count;
    if (flush) begin
      w_countNext = '0;
    end else if (w_wrAcc && !w_rdAcc) begin
      w_countNext = r_count + LP_ONE;
    end else if (w_rdAcc && !w_wrAcc) begin
      w_countNext = r_count - LP_ONE;
    end

    w_fullNext        = (w_countNext == LP_DEPTH);
    w_emptyNext       = (w_countNext == '0);
    w_almostFullNext  = (w_countNext >= LP_AF);
    w_almostEmptyNext = (w_countNext <= LP_AE);
  end

  // Array write port; flush suppresses the write in its cycle.
  always_ff @(posedge clk_100mhz) begin
    if (w_wrAcc && !flush) begin
      r_mem[r_wrPtr] <= wr_data;
    end
  end

  // Pointers, count, status flags, output register and sticky error flags.
  always_ff @(posedge clk_100mhz or negedge rst) begin
    if (!rst) begin
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
      r_count       <= '0;
      r_rdData      <= '0;
      r_rdValid     <= 1'b0;
      r_full        <= 1'b0;
      r_empty       <= 1'b1;
      r_almostFull  <= 1'b0;
      r_almostEmpty <= 1'b1;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_count       <= w_countNext;
      r_full        <= w_fullNext;
      r_empty       <= w_emptyNext;
      r_almostFull  <= w_almostFullNext;
      r_almostEmpty <= w_almostEmptyNext;
      if (flush) begin
        r_wrPtr     <= '0;
        r_rdPtr     <= '0;
        r_rdValid   <= 1'b0;
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end else begin
        if (w_wrAcc) begin
          r_wrPtr <= r_wrPtr + ADDR_W'(1);
        end
        if (w_memRead) begin
          r_rdPtr  <= r_rdPtr + ADDR_W'(1);
          r_rdData <= r_mem[r_rdPtr];
        end
        r_rdValid <= w_validNext;
        if (w_overflowHit) begin
          r_overflow <= 1'b1;
        end
        if (w_underflowHit) begin
          r_underflow <= 1'b1;
        end
      end
    end
  end

  assign rd_data      = r_rdData;
  assign rd_valid     = r_rdValid;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_almostFull;
  assign almost_empty = r_almostEmpty;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_pixel_fifo.sv
// Bench for pixel_fifo: one standard-mode and one FWFT-mode instance share the
// same stimulus and are each compared every cycle against a queue-based model.
module tb_pixel_fifo;

  localparam int DEPTH = 64;
  localparam int AF    = 56;
  localparam int AE    = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        wr_en;
  logic        rd_en;
  logic [23:0] wr_data;

  logic [23:0] rdDataS, rdDataF;
  logic        validS, validF, fullS, fullF, emptyS, emptyF;
  logic        afS, afF, aeS, aeF, ovS, ovF, unS, unF;
  logic [6:0]  countS, countF;

  int passCount  = 0;
  int failCount  = 0;
  int checkCount = 0;

  // Reference model state: the queue holds every stored word, oldest first.
  logic [23:0] qs[$];
  logic [23:0] qf[$];
  int          qfEdge[$];
  int          edgeNo = 0;
  logic [23:0] expDataS, expDataF;
  logic        expValidS, expValidF;
  logic        expOvS, expUnS, expOvF, expUnF;

  always #5 clk = ~clk;

  pixel_fifo #(.DATA_W(24), .ADDR_W(6), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) dutStd (
    .clk_100mhz(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rdDataS), .rd_valid(validS), .full(fullS), .empty(emptyS),
    .almost_full(afS), .almost_empty(aeS), .count(countS), .overflow(ovS), .underflow(unS)
  );

  pixel_fifo #(.DATA_W(24), .ADDR_W(6), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) dutFwft (
    .clk_100mhz(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rdDataF), .rd_valid(validF), .full(fullF), .empty(emptyF),
    .almost_full(afF), .almost_empty(aeF), .count(countF), .overflow(ovF), .underflow(unF)
  );

  // Single comparison point: counts, asserts and reports on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Model after reset: nothing stored, nothing presented, flags clear.
  task automatic modelReset();
    qs.delete();
    qf.delete();
    qfEdge.delete();
    expDataS  = '0;
    expDataF  = '0;
    expValidS = 1'b0;
    expValidF = 1'b0;
    expOvS    = 1'b0;
    expUnS    = 1'b0;
    expOvF    = 1'b0;
    expUnF    = 1'b0;
  endtask

  // Model of one rising edge using the inputs that were applied before it.
  task automatic modelEdge();
    logic rdAcc;
    logic wrAcc;
    edgeNo++;
    if (flush) begin
      qs.delete();
      qf.delete();
      qfEdge.delete();
      expValidS = 1'b0;
      expValidF = 1'b0;
      expOvS    = 1'b0;
      expUnS    = 1'b0;
      expOvF    = 1'b0;
      expUnF    = 1'b0;
    end else begin
      rdAcc = rd_en && (qs.size() > 0);
      wrAcc = wr_en && ((qs.size() < DEPTH) || rdAcc);
      if (rd_en && !rdAcc) expUnS = 1'b1;
      if (wr_en && !wrAcc) expOvS = 1'b1;
      expValidS = rdAcc;
      if (rdAcc) expDataS = qs.pop_front();
      if (wrAcc) qs.push_back(wr_data);

      rdAcc = rd_en && expValidF;
      wrAcc = wr_en && ((qf.size() < DEPTH) || rdAcc);
      if (rd_en && !rdAcc) expUnF = 1'b1;
      if (wr_en && !wrAcc) expOvF = 1'b1;
      if (rdAcc) begin
        void'(qf.pop_front());
        void'(qfEdge.pop_front());
      end
      if (wrAcc) begin
        qf.push_back(wr_data);
        qfEdge.push_back(edgeNo);
      end
      // A word becomes visible once it has been stored for at least one edge.
      expValidF = (qf.size() > 0) && (qfEdge[0] < edgeNo);
      if (expValidF) expDataF = qf[0];
    end
  endtask

  // Compare every output of both instances against the model.
  task automatic checkState();
    checkOutput("std.count",  32'(countS), 32'(qs.size()));
    checkOutput("std.full",   32'(fullS),  32'(qs.size() == DEPTH));
    checkOutput("std.empty",  32'(emptyS), 32'(qs.size() == 0));
    checkOutput("std.afull",  32'(afS),    32'(qs.size() >= AF));
    checkOutput("std.aempty", 32'(aeS),    32'(qs.size() <= AE));
    checkOutput("std.valid",  32'(validS), 32'(expValidS));
    checkOutput("std.rdData", 32'(rdDataS), 32'(expDataS));
    checkOutput("std.ovf",    32'(ovS),    32'(expOvS));
    checkOutput("std.unf",    32'(unS),    32'(expUnS));
    checkOutput("fwft.count",  32'(countF), 32'(qf.size()));
    checkOutput("fwft.full",   32'(fullF),  32'(qf.size() == DEPTH));
    checkOutput("fwft.empty",  32'(emptyF), 32'(qf.size() == 0));
    checkOutput("fwft.afull",  32'(afF),    32'(qf.size() >= AF));
    checkOutput("fwft.aempty", 32'(aeF),    32'(qf.size() <= AE));
    checkOutput("fwft.valid",  32'(validF), 32'(expValidF));
    checkOutput("fwft.ovf",    32'(ovF),    32'(expOvF));
    checkOutput("fwft.unf",    32'(unF),    32'(expUnF));
    if (expValidF) checkOutput("fwft.rdData", 32'(rdDataF), 32'(expDataF));
  endtask

  // Drive one cycle of inputs, advance one edge, update model, then check.
  task automatic applyStimulus(input logic we, input logic [23:0] wd, input logic re, input logic fl);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    flush   = fl;
    @(posedge clk);
    modelEdge();
    #1;
    checkState();
  endtask

  // Pulse reset for 3 ns between edges and check outputs with no clock edge.
  task automatic asyncReset();
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
    #2 rst = 1'b0;
    #2;
    modelReset();
    checkState();
    checkOutput("std.rdDataReset",  32'(rdDataS), 32'h0);
    checkOutput("fwft.rdDataReset", 32'(rdDataF), 32'h0);
    #1 rst = 1'b1;
  endtask

  initial begin
    rst     = 1'b0;
    flush   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    modelReset();
    #12;
    checkState();
    checkOutput("std.rdDataReset",  32'(rdDataS), 32'h0);
    checkOutput("fwft.rdDataReset", 32'(rdDataF), 32'h0);
    rst = 1'b1;

    $display("[TB] fill with 1..64 then overflow");
    for (int i = 1; i <= 64; i++) applyStimulus(1'b1, 24'(i), 1'b0, 1'b0);
    checkOutput("std.fullAfter64", 32'(fullS), 32'h1);
    checkOutput("std.afAfter64",   32'(afS),   32'h1);
    applyStimulus(1'b1, 24'h000041, 1'b0, 1'b0);
    checkOutput("std.overflow65", 32'(ovS),    32'h1);
    checkOutput("std.count65",    32'(countS), 32'd64);

    $display("[TB] drain in order then underflow");
    for (int i = 1; i <= 64; i++) begin
      applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
      checkOutput("std.drainData", 32'(rdDataS), 32'(i));
    end
    checkOutput("std.emptyAfterDrain", 32'(emptyS), 32'h1);
    applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
    checkOutput("std.underflow", 32'(unS), 32'h1);
    applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);

    $display("[TB] steady state at 32 with pointer wrap");
    for (int i = 0; i < 32; i++) applyStimulus(1'b1, 24'($urandom()), 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) applyStimulus(1'b1, 24'($urandom()), 1'b1, 1'b0);
    checkOutput("std.count32", 32'(countS), 32'd32);
    applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);

    $display("[TB] fwft latency");
    applyStimulus(1'b1, 24'hABCDEF, 1'b0, 1'b0);
    checkOutput("fwft.validEarly", 32'(validF), 32'h0);
    applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
    checkOutput("fwft.validLatency", 32'(validF),  32'h1);
    checkOutput("fwft.dataLatency",  32'(rdDataF), 32'hABCDEF);
    applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
    checkOutput("fwft.emptyAfterPop", 32'(emptyF), 32'h1);
    checkOutput("fwft.validAfterPop", 32'(validF), 32'h0);

    $display("[TB] flush with overflow set");
    for (int i = 0; i < 65; i++) applyStimulus(1'b1, 24'($urandom()), 1'b0, 1'b0);
    for (int i = 0; i < 54; i++) applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
    checkOutput("std.count10", 32'(countS), 32'd10);
    checkOutput("std.ovfHeld", 32'(ovS),    32'h1);
    applyStimulus(1'b1, 24'h777777, 1'b0, 1'b1);
    checkOutput("std.flushCount", 32'(countS), 32'h0);
    checkOutput("std.flushEmpty", 32'(emptyS), 32'h1);
    checkOutput("std.flushOvf",   32'(ovS),    32'h0);
    applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
    checkOutput("std.flushWriteIgnored", 32'(countS), 32'h0);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 99) < 55, 24'($urandom()),
                    $urandom_range(0, 99) < 50, $urandom_range(0, 199) == 0);
    end

    $display("[TB] async reset mid-operation");
    applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 24'($urandom()), 1'b0, 1'b0);
    checkOutput("std.count20", 32'(countS), 32'd20);
    asyncReset();
    applyStimulus(1'b1, 24'h123456, 1'b0, 1'b0);
    applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
    checkOutput("std.postResetValid",  32'(validS),  32'h1);
    checkOutput("std.postResetData",   32'(rdDataS), 32'h123456);
    checkOutput("fwft.postResetValid", 32'(validF),  32'h1);
    checkOutput("fwft.postResetData",  32'(rdDataF), 32'h123456);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pixel_fifo.md
PIXEL_FIFO -- requirements
Module: pixel_fifo

Interface
REQ-001 Parameter DATA_W, default 24: width of one pixel word (8b R, 8b G, 8b B packed {r,g,b}).
REQ-002 Parameter ADDR_W, default 6: depth is 2**ADDR_W words (64 by default).
REQ-003 Parameter AF_LEVEL, default 56: almost_full threshold in words; legal range 1..2**ADDR_W-1.
REQ-004 Parameter AE_LEVEL, default 8: almost_empty threshold in words; legal range 1..2**ADDR_W-1.
REQ-005 Parameter FWFT, default 0: 0 = standard read mode, 1 = first-word-fall-through mode.
REQ-006 Port clk_100mhz, input, 1: the single clock; all logic is clocked on its rising edge.
REQ-007 Port rst, input, 1: asynchronous, active-low reset.
REQ-008 Port flush, input, 1: synchronous clear of contents.
REQ-009 Port wr_en, input, 1: write request.
REQ-010 Port wr_data, input, DATA_W: write word.
REQ-011 Port rd_en, input, 1: read request; in FWFT mode it acknowledges the word on rd_data.
REQ-012 Port rd_data, output, DATA_W: read word.
REQ-013 Port rd_valid, output, 1: rd_data holds a valid word.
REQ-014 Port full, output, 1; port empty, output, 1.
REQ-015 Port almost_full, output, 1; port almost_empty, output, 1.
REQ-016 Port count, output, ADDR_W+1: number of stored words, 0..2**ADDR_W.
REQ-017 Port overflow, output, 1; port underflow, output, 1: sticky error flags.

Function
REQ-018 Storage SHALL be a 2**ADDR_W x DATA_W array with ADDR_W-bit read and write pointers that wrap from 2**ADDR_W-1 to 0.
REQ-019 count SHALL be registered and SHALL update on the same edge as the pointers: +1 on an accepted write only, -1 on an accepted read only, unchanged on both or neither.
REQ-020 full SHALL equal (count == 2**ADDR_W); empty SHALL equal (count == 0); almost_full SHALL equal (count >= AF_LEVEL); almost_empty SHALL equal (count <= AE_LEVEL). All four SHALL be registered and consistent with count in the same cycle.
REQ-021 A write SHALL be accepted when wr_en=1 and full=0, or when wr_en=1, full=1 and a read is accepted in the same cycle.
REQ-022 wr_en=1 with full=1 and no accepted read SHALL drop the word, leave the pointers unchanged, and set overflow.
REQ-023 Standard mode (FWFT=0): a read SHALL be accepted when rd_en=1 and empty=0; rd_data SHALL present the word on the next edge with rd_valid=1 for exactly one cycle; rd_data SHALL hold its value otherwise.
REQ-024 FWFT mode (FWFT=1): the oldest word SHALL appear on rd_data with rd_valid=1 without rd_en; rd_en=1 while rd_valid=1 SHALL pop it. Latency from a write into an empty FIFO to rd_valid=1 SHALL be 2 cycles. In this mode count SHALL include the presented word.
REQ-025 rd_en=1 with no word available (empty in standard mode, rd_valid=0 in FWFT mode) SHALL set underflow and leave the state unchanged.
REQ-026 A simultaneous accepted write and read when empty=0 SHALL leave count unchanged. When empty=1, rd_en SHALL NOT return the word written in the same cycle.
REQ-027 flush=1 SHALL, on the next edge, zero the pointers and count, deassert rd_valid, and clear overflow and underflow. Flush SHALL override wr_en and rd_en in that cycle.
REQ-028 overflow and underflow SHALL remain set until reset or flush.

Reset
REQ-029 rst=0 SHALL immediately force: pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, rd_valid=0, rd_data=0, overflow=0, underflow=0.
REQ-030 Memory contents SHALL NOT be reset and SHALL never be observable before they are written.
REQ-031 Reset asserted mid-operation SHALL discard all stored words, and the first read after release SHALL return only data written after release.

Verification
REQ-032 Defaults, FWFT=0: write 0x000001..0x000040 on consecutive cycles -> full=1 after the 64th write; almost_full=1 once count>=56; a 65th write sets overflow=1 and count stays 64.
REQ-033 Drain the full FIFO with rd_en held high -> rd_data is 0x000001..0x000040 in order, each one cycle after its rd_en; empty=1 after the last read; one further rd_en sets underflow=1.
REQ-034 count=32, wr_en=rd_en=1 for 100 cycles with pointer wrap -> count stays 32 and output order is preserved across the wrap.
REQ-035 FWFT=1: write 0xABCDEF into an empty FIFO -> rd_valid=1 with rd_data=0xABCDEF two cycles later, without rd_en; rd_en=1 then gives empty=1 and rd_valid=0.
REQ-036 Hold count=10 with overflow=1, then pulse flush -> count=0, empty=1, overflow=0 on the next edge; a write in the flush cycle is ignored.
REQ-037 With count=20, drive rst low for 3 ns between edges -> all outputs reach their reset values without a clock edge; after release, write 0x123456 and read -> 0x123456.
